// File: rtl/goertzel_mag_detect_pkg.sv
// Shared constants and state encoding for the Goertzel bin-power stage.
// D_W        : width of T1, T2 and coeff (coeff is signed fix 2.14)
// P_W        : width of power and threshold (unsigned)
// ACC_W      : signed accumulator width, wide enough that T1^2+T2^2-coeff*T1*T2
//              never wraps
// CT_W       : width of the rescaled coeff*T1 term and of the multiplier A port
// COEFF_FRAC : fractional bits of coeff
// PROD_W     : multiplier product width (CT_W x D_W)
package goertzel_mag_detect_pkg;

  localparam int D_W        = 16;
  localparam int P_W        = 33;
  localparam int ACC_W      = 35;
  localparam int CT_W       = 18;
  localparam int COEFF_FRAC = 14;
  localparam int PROD_W     = CT_W + D_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQ1  = 3'd1,
    ST_SQ2  = 3'd2,
    ST_CT1  = 3'd3,
    ST_HOLD = 3'd4,
    ST_XT2  = 3'd5,
    ST_SUB  = 3'd6
  } state_t;

endpackage

// File: rtl/goertzel_mag_mul.sv
// Registered signed multiplier, CT_W x D_W -> PROD_W. Kept in its own module
// so it can be mapped onto a DSP tile. The product appears the cycle after the
// operands are presented with ce high, and holds while ce is low.
//   clk   : clock
//   rst_n : asynchronous active-low clear of the product register
//   ce    : clock enable
//   a     : signed CT_W-bit operand
//   b     : signed D_W-bit operand
//   p     : signed PROD_W-bit registered product
module goertzel_mag_mul
  import goertzel_mag_detect_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic signed [CT_W-1:0]   a,
  input  logic signed [D_W-1:0]    b,
  output logic signed [PROD_W-1:0] p
);

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its sources; blocking = here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (ce) begin
      p <= PROD_W'(a) * PROD_W'(b);
    end
  end

endmodule

// File: rtl/goertzel_mag_detect.sv
// Post-processing stage after the Goertzel loop core. A rising edge on
// core_done captures T1/T2/coeff/threshold, then the bin power
//   P = T1^2 + T2^2 - coeff*T1*T2
// is built over six cycles through one shared registered multiplier. The
// result is clamped at zero, compared with the threshold and posted with a
// one-cycle valid pulse.
//   sys_clk   : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   core_done : level done from the loop core; a 0->1 edge starts a computation
//   T1, T2    : signed final states s[N-1], s[N-2]
//   coeff     : signed fix 2.14 coefficient 2cos(w)
//   threshold : unsigned detection threshold
//   power     : unsigned bin power of the last computation
//   detect    : power >= threshold for the last computation
//   valid     : one-cycle pulse when power/detect update
//   busy      : high while a computation is in flight
module goertzel_mag_detect
  import goertzel_mag_detect_pkg::*;
(
  input  logic           sys_clk,
  input  logic           rst_n,
  input  logic           core_done,
  input  logic [D_W-1:0] T1,
  input  logic [D_W-1:0] T2,
  input  logic [D_W-1:0] coeff,
  input  logic [P_W-1:0] threshold,
  output logic [P_W-1:0] power,
  output logic           detect,
  output logic           valid,
  output logic           busy
);

  state_t                     state;
  logic                       done_q;
  logic signed [D_W-1:0]      t1_r;
  logic signed [D_W-1:0]      t2_r;
  logic signed [D_W-1:0]      coeff_r;
  logic        [P_W-1:0]      thr_r;
  logic signed [ACC_W-1:0]    acc;
  logic signed [CT_W-1:0]     ct1;

  logic                       trigger;
  logic                       mul_ce;
  logic signed [CT_W-1:0]     mul_a;
  logic signed [D_W-1:0]      mul_b;
  logic signed [PROD_W-1:0]   mul_p;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_diff;
  logic        [P_W-1:0]      pow_next;

  assign trigger  = core_done & ~done_q;
  assign prod_ext = {{(ACC_W-PROD_W){mul_p[PROD_W-1]}}, mul_p};
  assign acc_diff = acc - prod_ext;
  // A negative result can only come from rounding in ct1; report it as zero.
  assign pow_next = acc_diff[ACC_W-1] ? '0 : acc_diff[P_W-1:0];

  // Operand select for the shared multiplier; the product is consumed one
  // state later.
  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    mul_ce = 1'b0;
    mul_a  = '0;
    mul_b  = '0;
    unique case (state)
      ST_SQ1: begin
        mul_ce = 1'b1;
        mul_a  = {{(CT_W-D_W){t1_r[D_W-1]}}, t1_r};
        mul_b  = t1_r;
      end
      ST_SQ2: begin
        mul_ce = 1'b1;
        mul_a  = {{(CT_W-D_W){t2_r[D_W-1]}}, t2_r};
        mul_b  = t2_r;
      end
      ST_CT1: begin
        mul_ce = 1'b1;
        mul_a  = {{(CT_W-D_W){coeff_r[D_W-1]}}, coeff_r};
        mul_b  = t1_r;
      end
      ST_XT2: begin
        mul_ce = 1'b1;
        mul_a  = ct1;
        mul_b  = t2_r;
      end
      default: ;
    endcase
  end

  goertzel_mag_mul u_mul (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .ce    (mul_ce),
    .a     (mul_a),
    .b     (mul_b),
    .p     (mul_p)
  );

  // NOTE: the datapath registers are reset along with the control state, so a
  // reset mid-computation leaves no stale operands behind and every register
  // starts from a known zero.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      done_q  <= 1'b0;
      t1_r    <= '0;
      t2_r    <= '0;
      coeff_r <= '0;
      thr_r   <= '0;
      acc     <= '0;
      ct1     <= '0;
      power   <= '0;
      detect  <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done_q <= core_done;
      valid  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (trigger) begin
            t1_r    <= T1;
            t2_r    <= T2;
            coeff_r <= coeff;
            thr_r   <= threshold;
            busy    <= 1'b1;
            state   <= ST_SQ1;
          end
        end
        ST_SQ1: state <= ST_SQ2;
        ST_SQ2: begin
          acc   <= prod_ext;
          state <= ST_CT1;
        end
        ST_CT1: begin
          acc   <= acc + prod_ext;
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          // Bit slice of the product is an arithmetic (floor) shift by
          // COEFF_FRAC; |coeff*T1| >> 14 never exceeds 65536, so CT_W bits hold it.
          ct1   <= mul_p[CT_W+COEFF_FRAC-1:COEFF_FRAC];
          state <= ST_XT2;
        end
        ST_XT2: state <= ST_SUB;
        ST_SUB: begin
          acc    <= acc_diff;
          power  <= pow_next;
          detect <= (pow_next >= thr_r);
          valid  <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_mag_detect.sv
// Self-checking bench for goertzel_mag_detect: a directed vector table, a
// randomized run against an arithmetic reference model, and hand-written
// sequences for retrigger and reset-in-flight behaviour.
module tb_goertzel_mag_detect;

  logic        sys_clk;
  logic        rst_n;
  logic        core_done;
  logic [15:0] T1;
  logic [15:0] T2;
  logic [15:0] coeff;
  logic [32:0] threshold;
  logic [32:0] power;
  logic        detect;
  logic        valid;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  goertzel_mag_detect dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .core_done (core_done),
    .T1        (T1),
    .T2        (T2),
    .coeff     (coeff),
    .threshold (threshold),
    .power     (power),
    .detect    (detect),
    .valid     (valid),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint actual, input longint expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // floor(a / b) for b > 0
  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Bin power straight from the definition: ct1 = floor(coeff*T1 / 2^14),
  // P = T1^2 + T2^2 - ct1*T2, negative results reported as zero.
  function automatic longint model_power(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
    longint t1, t2, cf, ct, p;
    t1 = longint'($signed(a));
    t2 = longint'($signed(b));
    cf = longint'($signed(c));
    ct = floor_div(cf * t1, 16384);
    p  = t1 * t1 + t2 * t2 - ct * t2;
    return (p < 0) ? 0 : p;
  endfunction

  // One full computation: raise core_done, wait (bounded) for valid.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [32:0] thr, output logic [32:0] pow,
                        output logic det, output int lat);
    @(negedge sys_clk);
    T1 = a; T2 = b; coeff = c; threshold = thr; core_done = 1'b1;
    lat = -1; pow = '0; det = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge sys_clk);
      if (n == 1) check("busy_after_trigger", longint'(busy), 1);
      if (valid) begin
        lat = n - 1; pow = power; det = detect;
        break;
      end
    end
    core_done = 1'b0;
    if (lat >= 0) begin
      @(negedge sys_clk);
      check("valid_single_cycle", longint'(valid), 0);
      check("power_held", longint'(power), longint'(pow));
    end
  endtask

  // First trigger with X, then drop core_done and raise it again so that the
  // second rising edge is sampled k cycles after the first.
  task automatic seq_two(input string tag,
                         input logic [15:0] xa, input logic [15:0] xb, input logic [15:0] xc,
                         input logic [15:0] ya, input logic [15:0] yb, input logic [15:0] yc,
                         input int k, input int exp_count, input longint exp_last);
    int cnt, first;
    longint last;
    @(negedge sys_clk);
    T1 = xa; T2 = xb; coeff = xc; threshold = '0; core_done = 1'b1;
    cnt = 0; first = -1; last = -1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge sys_clk);
      if (valid) begin
        cnt++;
        if (first < 0) first = n - 1;
        last = longint'(power);
      end
      if (n == 1) begin
        core_done = 1'b0;
        T1 = ya; T2 = yb; coeff = yc;
      end
      if (n == k) core_done = 1'b1;
    end
    core_done = 1'b0;
    check({tag, "_valid_count"}, cnt, exp_count);
    check({tag, "_first_latency"}, first, 6);
    check({tag, "_last_power"}, last, exp_last);
  endtask

  typedef struct {
    logic [15:0] t1;
    logic [15:0] t2;
    logic [15:0] cf;
    logic [32:0] thr;
    longint      exp_pow;
    logic        exp_det;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [32:0] pow;
    logic        det;
    int          lat;
    longint      p, thr_l;
    logic [15:0] ra, rb, rc;
    int          cnt;

    vecs[0] = '{16'd100,  16'd0,    16'h4000, 33'd10000,      10000,       1'b1};
    vecs[1] = '{16'd100,  16'd0,    16'h4000, 33'd10001,      10000,       1'b0};
    vecs[2] = '{16'd100,  16'd100,  16'h8000, 33'd50000,      40000,       1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 16'h8000, 33'h1_0000_0000, 64'd4294967296, 1'b1};
    vecs[4] = '{16'hFFFB, 16'hFFFC, 16'h7FFF, 33'd1,          1,           1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 33'd0,          0,           1'b1};

    rst_n = 1'b0; core_done = 1'b0;
    T1 = '0; T2 = '0; coeff = '0; threshold = '0;
    repeat (3) @(negedge sys_clk);
    check("reset_power",  longint'(power),  0);
    check("reset_detect", longint'(detect), 0);
    check("reset_valid",  longint'(valid),  0);
    check("reset_busy",   longint'(busy),   0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].t1, vecs[i].t2, vecs[i].cf, vecs[i].thr, pow, det, lat);
      check($sformatf("vec%0d_latency", i), lat, 6);
      check($sformatf("vec%0d_power", i), longint'(pow), vecs[i].exp_pow);
      check($sformatf("vec%0d_detect", i), longint'(det), longint'(vecs[i].exp_det));
    end

    // Randomized against the reference model, thresholds placed around P
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = 16'($urandom_range(0, 65535));
      p  = model_power(ra, rb, rc);
      thr_l = p - 1 + longint'($urandom_range(0, 2));
      if (thr_l < 0) thr_l = 0;
      run_op(ra, rb, rc, thr_l[32:0], pow, det, lat);
      check($sformatf("rnd%0d_latency", i), lat, 6);
      check($sformatf("rnd%0d_power", i), longint'(pow), p);
      check($sformatf("rnd%0d_detect", i), longint'(det), (p >= thr_l) ? 1 : 0);
    end

    // Retrigger 3 cycles after: discarded, results from the first capture
    seq_two("retrig3", 16'd100, 16'd0, 16'h4000, 16'd300, 16'd200, 16'h4000, 3, 1,
            model_power(16'd100, 16'd0, 16'h4000));
    // Retrigger 7 cycles after: accepted, second result from the new capture
    seq_two("retrig7", 16'd100, 16'd0, 16'h4000, 16'd300, 16'd200, 16'h4000, 7, 2,
            model_power(16'd300, 16'd200, 16'h4000));

    // Reset while in HOLD (after E3)
    @(negedge sys_clk);
    T1 = 16'd500; T2 = 16'd7; coeff = 16'h2000; threshold = '0; core_done = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("pre_reset_busy", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midreset_power",  longint'(power),  0);
    check("midreset_detect", longint'(detect), 0);
    check("midreset_valid",  longint'(valid),  0);
    check("midreset_busy",   longint'(busy),   0);
    core_done = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge sys_clk);
      if (valid) cnt++;
    end
    check("after_abort_valid_count", cnt, 0);

    // core_done held high through reset release: exactly one computation
    @(negedge sys_clk);
    rst_n = 1'b0;
    T1 = 16'hFC18; T2 = 16'd1234; coeff = 16'hC000; core_done = 1'b1;
    @(negedge sys_clk);
    rst_n = 1'b1;
    cnt = 0; p = -1;
    for (int n = 0; n < 24; n++) begin
      @(negedge sys_clk);
      if (valid) begin
        cnt++;
        p = longint'(power);
      end
    end
    core_done = 1'b0;
    check("held_done_valid_count", cnt, 1);
    check("held_done_power", p, model_power(16'hFC18, 16'd1234, 16'hC000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
